// File: rtl/crc_append.sv
// rtl/crc_append.sv - byte-stream CRC appender: passes payload through, then appends CW/8 CRC bytes
module crc_append #(
  parameter int            CW   = 16,
  parameter logic [CW-1:0] POLY = 16'h1021,
  parameter logic [CW-1:0] INIT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    din,
  input  logic          din_valid,
  input  logic          din_last,
  output logic          din_ready,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic          dout_last,
  input  logic          dout_ready,
  output logic [CW-1:0] crc,
  output logic [15:0]   frame_cnt
);

  localparam logic [2:0] NB = 3'(CW / 8);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] crc_reg;
  logic [2:0]    crc_idx;
  logic [CW-1:0] crc_sh;
  logic [7:0]    crc_sel;
  logic          in_xfer;
  logic          out_xfer;
  logic          out_free;
  logic          frame_done;

  // MSB-first, non-reflected byte update; din bit 7 enters the register first
  function automatic logic [CW-1:0] crc_byte(input logic [CW-1:0] c_in, input logic [7:0] d);
    logic [CW-1:0] c;
    logic          fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CW-1] ^ d[i];
      c  = {c[CW-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  assign in_xfer    = din_valid && din_ready;
  assign out_xfer   = dout_valid && dout_ready;
  // output register can take a new byte when it is empty or being drained this cycle
  assign out_free   = !dout_valid || dout_ready;
  assign frame_done = (state == CRC) && out_xfer && dout_last;

  // CRC bytes go out most significant first: shift the wanted byte to the top
  assign crc_sh  = crc_reg << {crc_idx, 3'b000};
  assign crc_sel = crc_sh[CW-1 -: 8];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DATA: if (in_xfer) state_nxt = din_last ? CRC : DATA;
      CRC:        if (frame_done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // input handshake: no new payload while CRC bytes are pending
  always_comb begin
    din_ready = (state != CRC) && out_free;
  end

  // output register, running CRC and frame bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      crc_reg    <= INIT;
      crc_idx    <= 3'd0;
      crc        <= '0;
      frame_cnt  <= 16'd0;
    end else if (in_xfer) begin
      dout       <= din;
      dout_valid <= 1'b1;
      dout_last  <= 1'b0;
      crc_reg    <= crc_byte(crc_reg, din);
    end else if (state == CRC) begin
      if (frame_done) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
        crc        <= crc_reg;
        frame_cnt  <= frame_cnt + 16'd1;
        crc_reg    <= INIT;
        crc_idx    <= 3'd0;
      end else if (out_free && crc_idx != NB) begin
        dout       <= crc_sel;
        dout_valid <= 1'b1;
        dout_last  <= (crc_idx == NB - 3'd1);
        crc_idx    <= crc_idx + 3'd1;
      end else if (out_xfer) begin
        dout_valid <= 1'b0;
      end
    end else if (out_xfer) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc_append.sv
// tb/tb_crc_append.sv - self-checking bench for crc_append (CW=16 main, CW=8/32 known answers)
module tb_crc_append;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          len;
    logic [7:0]  b [12];
    logic [15:0] crc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_last = 1'b0;
  logic        din_valid16 = 1'b0;
  logic        din_valid_o = 1'b0;
  logic        dout_ready16 = 1'b1;
  logic        dout_ready_o = 1'b1;

  logic        din_ready16, dout_valid16, dout_last16;
  logic [7:0]  dout16;
  logic [15:0] crc16, frame_cnt16;
  logic        din_ready8, dout_valid8, dout_last8;
  logic [7:0]  dout8, crc8;
  logic [15:0] frame_cnt8;
  logic        din_ready32, dout_valid32, dout_last32;
  logic [7:0]  dout32;
  logic [31:0] crc32;
  logic [15:0] frame_cnt32;

  int   checks = 0;
  int   errors = 0;
  bit   thr = 0;
  bit   in_crc = 0;
  bit   stall16 = 0;
  logic [8:0] p_out;
  int   done16 = 0;
  logic [8:0] q16[$];
  logic [8:0] q8[$];
  logic [8:0] q32[$];

  always #5 clk = ~clk;

  crc_append #(.CW(16), .POLY(16'h1021), .INIT(16'hFFFF)) u16 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid16), .din_last(din_last),
    .din_ready(din_ready16), .dout(dout16), .dout_valid(dout_valid16), .dout_last(dout_last16),
    .dout_ready(dout_ready16), .crc(crc16), .frame_cnt(frame_cnt16));

  crc_append #(.CW(8), .POLY(8'h9B), .INIT(8'hFF)) u8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid_o), .din_last(din_last),
    .din_ready(din_ready8), .dout(dout8), .dout_valid(dout_valid8), .dout_last(dout_last8),
    .dout_ready(dout_ready_o), .crc(crc8), .frame_cnt(frame_cnt8));

  crc_append #(.CW(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF)) u32 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid_o), .din_last(din_last),
    .din_ready(din_ready32), .dout(dout32), .dout_valid(dout_valid32), .dout_last(dout_last32),
    .dout_ready(dout_ready_o), .crc(crc32), .frame_cnt(frame_cnt32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference CRC as polynomial long division: remainder of (INIT*x^(8n) + M*x^16) mod G
  function automatic logic [15:0] model_crc(input bq_t msg);
    bit          bits[$];
    logic [16:0] gen = {1'b1, 16'h1021};
    logic [15:0] init = 16'hFFFF;
    logic [15:0] r;
    int          n = msg.size() * 8;
    foreach (msg[k]) for (int j = 7; j >= 0; j--) bits.push_back(msg[k][j]);
    for (int j = 0; j < 16; j++) bits.push_back(1'b0);
    for (int j = 0; j < 16; j++) bits[j] = bits[j] ^ init[15-j];
    for (int i = 0; i < n; i++)
      if (bits[i]) for (int j = 0; j <= 16; j++) bits[i+j] = bits[i+j] ^ gen[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = bits[n+j];
    return r;
  endfunction

  // random downstream back-pressure when throttling is enabled
  always @(posedge clk) begin
    #1;
    dout_ready16 = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // output monitor: collects transfers, checks hold-while-stalled and no input during CRC
  always @(negedge clk) begin
    if (rst) begin
      stall16 = 0;
    end else begin
      if (stall16) begin
        chk("hold_valid", 32'(dout_valid16), 32'd1);
        chk("hold_data", 32'({dout_last16, dout16}), 32'(p_out));
      end
      if (in_crc) chk("ready_in_crc", 32'(din_ready16), 32'd0);
      if (dout_valid16 && dout_ready16) begin
        q16.push_back({dout_last16, dout16});
        if (dout_last16) begin
          in_crc = 0;
          done16++;
        end
      end
      stall16 = dout_valid16 && !dout_ready16;
      p_out   = {dout_last16, dout16};
      if (dout_valid8 && dout_ready_o)  q8.push_back({dout_last8, dout8});
      if (dout_valid32 && dout_ready_o) q32.push_back({dout_last32, dout32});
    end
  end

  // drive one frame into the CW=16 instance; called and returns at posedge+1
  task automatic send16(input bq_t msg, input bit thr_in, input bit give_last);
    for (int k = 0; k < msg.size(); k++) begin
      int w = 0;
      bit acc = 0;
      while (!acc) begin
        din         = msg[k];
        din_last    = give_last && (k == msg.size() - 1);
        din_valid16 = thr_in ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        acc = din_valid16 && din_ready16;
        @(posedge clk); #1;
        w++;
        if (w > 300) begin
          checks++; errors++;
          $display("FAIL send_timeout byte=%0d actual=stuck required=accepted", k);
          din_valid16 = 1'b0;
          return;
        end
      end
      if (din_last) in_crc = 1;
    end
    din_valid16 = 1'b0;
    din_last    = 1'b0;
  endtask

  task automatic run_frame(input bq_t msg, input bit thr_in, input logic [15:0] exp_crc,
                           input int exp_cnt);
    int target = done16 + 1;
    int w = 0;
    q16.delete();
    thr = thr_in;
    send16(msg, thr_in, 1'b1);
    while (done16 < target && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    thr = 0;
    chk("frame_done", 32'(done16 >= target), 32'd1);
    chk("out_len", 32'(q16.size()), 32'(msg.size() + 2));
    if (q16.size() == msg.size() + 2) begin
      foreach (msg[k]) chk("payload", 32'(q16[k]), 32'({1'b0, msg[k]}));
      chk("crc_hi_byte", 32'(q16[msg.size()]), 32'({1'b0, exp_crc[15:8]}));
      chk("crc_lo_byte", 32'(q16[msg.size()+1]), 32'({1'b1, exp_crc[7:0]}));
    end
    chk("crc_out", 32'(crc16), 32'(exp_crc));
    chk("frame_cnt", 32'(frame_cnt16), 32'(exp_cnt));
  endtask

  initial begin
    vec_t vt[3];
    bq_t  m;
    int   nframes = 0;

    vt[0].len = 9; vt[0].crc = 16'h29B1;
    for (int i = 0; i < 9; i++) vt[0].b[i] = 8'h31 + 8'(i);
    vt[1].len = 1; vt[1].crc = 16'hB915; vt[1].b[0] = 8'h41;
    vt[2].len = 1; vt[2].crc = 16'hE1F0; vt[2].b[0] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid16), 32'd0);
    chk("rst_dout", 32'(dout16), 32'd0);
    chk("rst_crc", 32'(crc16), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(din_ready16), 32'd1);
    chk("rst_frame_cnt", 32'(frame_cnt16), 32'd0);
    @(posedge clk); #1;

    // partial frame killed by reset
    m = {8'h31, 8'h32, 8'h33, 8'h34};
    send16(m, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(dout_valid16), 32'd0);
    chk("mid_rst_dout", 32'(dout16), 32'd0);
    chk("mid_rst_last", 32'(dout_last16), 32'd0);
    chk("mid_rst_crc", 32'(crc16), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt16), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", 32'(din_ready16), 32'd1);
    @(posedge clk); #1;
    chk("no_crc_emitted", 32'(done16), 32'd0);

    // table vectors back to back, ending with the single-byte 0x00 frame
    for (int v = 0; v < 3; v++) begin
      m.delete();
      for (int i = 0; i < vt[v].len; i++) m.push_back(vt[v].b[i]);
      nframes++;
      run_frame(m, 1'b0, vt[v].crc, nframes);
    end

    // CW=8 and CW=32 known answers on "123456789"
    q8.delete(); q32.delete();
    for (int i = 0; i < 9; i++) begin
      din = 8'h31 + 8'(i); din_last = (i == 8); din_valid_o = 1'b1;
      @(posedge clk); #1;
    end
    din_valid_o = 1'b0; din_last = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("cw8_len", 32'(q8.size()), 32'd10);
    if (q8.size() == 10) chk("cw8_last_byte", 32'(q8[9]), 32'h1DA);
    chk("cw8_crc", 32'(crc8), 32'hDA);
    chk("cw32_len", 32'(q32.size()), 32'd13);
    if (q32.size() == 13) begin
      chk("cw32_b0", 32'(q32[9]), 32'h003);
      chk("cw32_b1", 32'(q32[10]), 32'h076);
      chk("cw32_b2", 32'(q32[11]), 32'h0E6);
      chk("cw32_b3", 32'(q32[12]), 32'h1E7);
    end
    chk("cw32_crc", crc32, 32'h0376E6E7);

    // throttled "123456789" then random frames against the model
    m.delete();
    for (int i = 0; i < 9; i++) m.push_back(8'h31 + 8'(i));
    nframes++;
    run_frame(m, 1'b1, 16'h29B1, nframes);
    for (int f = 0; f < 8; f++) begin
      int len = $urandom_range(1, 12);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      nframes++;
      run_frame(m, 1'b1, model_crc(m), nframes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
